input_state: RTL and testbench
==============================

INPUT_STATE -- requirements
Module: input_state

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept a press or a release.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: idle cycles allowed in WAIT_PRESS before timeout (only with INPUT_TIMEOUT_EN).
REQ-003 clk  input  1  single system clock; all logic on posedge.
REQ-004 rst_input  input  1  synchronous, active-high reset.
REQ-005 en_input  input  1  start pulse; sampled only in IDLE.
REQ-006 buttons  input  4  raw player buttons, one bit per colour.
REQ-007 round_ctr_in  input  4  current round; the round requires round_ctr_in+1 presses.
REQ-008 seq_in_check  output  32  packed player sequence fed to the checker.
REQ-009 complete_input  output  1  one-cycle pulse when the sequence is ready.
REQ-010 press_count  output  5  presses accepted in the current round, 0..16.
REQ-011 timed_out  output  1  one-cycle pulse coincident with a timeout-driven complete_input.

Function
REQ-012 States: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
REQ-013 IDLE with en_input=1: next cycle WAIT_PRESS; seq_in_check=0, press_count=0, target=round_ctr_in+1 latched (5 bits, 1..16).
REQ-014 en_input outside IDLE is ignored; round_ctr_in changes after latching are ignored.
REQ-015 Encoding: buttons 4'b0001->2'b00, 4'b0010->2'b01, 4'b0100->2'b10, 4'b1000->2'b11.
REQ-016 Press accepted in WAIT_PRESS when buttons holds the same one-hot value for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count.
REQ-017 Zero or multi-bit button values never count toward a press and restart the debounce count.
REQ-018 On acceptance: symbol written to seq_in_check[2k+1:2k], k = press_count before increment; press_count increments; next state WAIT_RELEASE.
REQ-019 Bits above the last written symbol remain 0.
REQ-020 WAIT_RELEASE: buttons==0 for DEBOUNCE_CYCLES consecutive cycles ends the release; then DONE if press_count==target, else WAIT_PRESS.
REQ-021 DONE lasts exactly one cycle: complete_input=1, then IDLE.
REQ-022 seq_in_check and press_count hold their values in IDLE until the next accepted en_input.
REQ-023 A button held across the transition into WAIT_PRESS counts only after DEBOUNCE_CYCLES stable cycles in WAIT_PRESS.
REQ-024 Round 15 fills all 32 bits; press_count reaches 16 without wrap.

Reset
REQ-025 rst_input at any cycle, mid-sequence included, wins over all other inputs: state IDLE, seq_in_check=0, press_count=0, complete_input=0, timed_out=0, all counters 0.

Configuration
REQ-026 Macro INPUT_TIMEOUT_EN defined: a counter runs in WAIT_PRESS, cleared on each accepted press and on entry from IDLE.
REQ-027 The counter reaching TIMEOUT_CYCLES moves to DONE with timed_out=1 for that cycle; the partial seq_in_check is presented.
REQ-028 Macro INPUT_TIMEOUT_EN undefined: no timeout logic; timed_out is tied 0; WAIT_PRESS waits indefinitely.

Verification
REQ-029 Reset, en_input with round_ctr_in=0, buttons=4'b0100 for 4 cycles then 0 for 4 -> one complete_input pulse, seq_in_check=32'h00000002, press_count=1.
REQ-030 round_ctr_in=3, presses 0001,0010,0100,1000, each debounced -> seq_in_check=32'h000000E4, press_count=4, complete_input once.
REQ-031 buttons=4'b0011 for 20 cycles, then 4'b0001 held 3 cycles and released -> no press accepted, press_count=0, no complete_input.
REQ-032 round_ctr_in=15, 16 presses of 4'b1000 -> seq_in_check=32'hFFFFFFFF, press_count=16.
REQ-033 rst_input asserted after 2 of 4 presses -> next cycle IDLE, seq_in_check=0, press_count=0; the following en_input starts a clean round.
REQ-034 INPUT_TIMEOUT_EN defined, TIMEOUT_CYCLES=50, one press then idle -> after 50 cycles complete_input and timed_out pulse together, press_count=1; macro undefined -> no pulse after 200 cycles.

Source files
------------

// File: rtl/input_state.sv
// Debounced 4-button sequence capture: collects round_ctr_in+1 one-hot presses into 2-bit symbols, pulses complete_input for one cycle.
// Press/release accepted after DEBOUNCE_CYCLES stable samples; optional WAIT_PRESS timeout under `INPUT_TIMEOUT_EN.
module input_state #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic        clk,
  input  logic        rst_input,
  input  logic        en_input,
  input  logic [3:0]  buttons,
  input  logic [3:0]  round_ctr_in,
  output logic [31:0] seq_in_check,
  output logic        complete_input,
  output logic [4:0]  press_count,
  output logic        timed_out
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DB_W-1:0] db_cnt;
  logic [DB_W-1:0] db_cnt_nxt;
  logic [3:0]      db_val;
  logic [4:0]      target;
  logic            btn_onehot;
  logic            btn_zero;
  logic            press_ok;
  logic            release_ok;
  logic            timeout_hit;
  logic [1:0]      sym;

  assign btn_zero   = (buttons == 4'd0);
  assign btn_onehot = !btn_zero && ((buttons & (buttons - 4'd1)) == 4'd0);

  always_comb begin
    sym = 2'b00;
    case (buttons)
      4'b0001: sym = 2'b00;
      4'b0010: sym = 2'b01;
      4'b0100: sym = 2'b10;
      4'b1000: sym = 2'b11;
      default: sym = 2'b00;
    endcase
  end

  // One shared counter: stable one-hot samples in WAIT_PRESS, zero samples in WAIT_RELEASE.
  always_comb begin
    db_cnt_nxt = '0;
    press_ok   = 1'b0;
    release_ok = 1'b0;
    case (state)
      WAIT_PRESS: begin
        if (btn_onehot) begin
          if ((buttons == db_val) && (db_cnt != '0)) begin
            db_cnt_nxt = db_cnt + 1'b1;
          end else begin
            db_cnt_nxt = DB_W'(1);
          end
          press_ok = (db_cnt_nxt == DB_W'(DEBOUNCE_CYCLES));
        end
      end
      WAIT_RELEASE: begin
        if (btn_zero) begin
          db_cnt_nxt = db_cnt + 1'b1;
          release_ok = (db_cnt_nxt == DB_W'(DEBOUNCE_CYCLES));
        end
      end
      default: begin
        db_cnt_nxt = '0;
      end
    endcase
  end

`ifdef INPUT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_flag;

  // A press landing on the final idle cycle takes priority over the timeout.
  assign timeout_hit = (state == WAIT_PRESS) && !press_ok &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst_input) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if ((state == WAIT_PRESS) && !press_ok) begin
        to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end
      to_flag <= timeout_hit;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk) begin
    if (rst_input) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (en_input) begin
          state_nxt = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (press_ok) begin
          state_nxt = WAIT_RELEASE;
        end else if (timeout_hit) begin
          state_nxt = DONE;
        end
      end
      WAIT_RELEASE: begin
        if (release_ok) begin
          state_nxt = (press_count == target) ? DONE : WAIT_PRESS;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    complete_input = (state == DONE);
`ifdef INPUT_TIMEOUT_EN
    timed_out = to_flag;
`else
    timed_out = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst_input) begin
      db_cnt       <= '0;
      db_val       <= 4'd0;
      target       <= 5'd0;
      seq_in_check <= 32'd0;
      press_count  <= 5'd0;
    end else begin
      db_val <= buttons;
      db_cnt <= (press_ok || release_ok) ? '0 : db_cnt_nxt;
      if ((state == IDLE) && en_input) begin
        seq_in_check <= 32'd0;
        press_count  <= 5'd0;
        target       <= {1'b0, round_ctr_in} + 5'd1;
      end else if (press_ok) begin
        seq_in_check[{press_count[3:0], 1'b0} +: 2] <= sym;
        press_count <= press_count + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_input_state.sv
// Directed bench for input_state with a sample-history reference model checked every cycle.
module tb_input_state;

  localparam int D  = 4;
  localparam int TO = 50;
`ifdef INPUT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_input;
  logic        en_input;
  logic [3:0]  buttons;
  logic [3:0]  round_ctr_in;
  logic [31:0] seq_in_check;
  logic        complete_input;
  logic [4:0]  press_count;
  logic        timed_out;

  int checks;
  int failures;
  int pulses;
  int to_pulses;

  int         m_phase;
  logic [31:0] m_seq;
  int         m_pc;
  int         m_target;
  int         m_idle;
  bit         m_to;
  logic [3:0] m_hist[$];

  input_state #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_input(rst_input),
    .en_input(en_input),
    .buttons(buttons),
    .round_ctr_in(round_ctr_in),
    .seq_in_check(seq_in_check),
    .complete_input(complete_input),
    .press_count(press_count),
    .timed_out(timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit last_d_stable(bit want_zero);
    logic [3:0] v;
    int n;
    n = m_hist.size();
    if (n < D) return 1'b0;
    v = m_hist[n-D];
    for (int i = n - D; i < n; i++) begin
      if (m_hist[i] !== v) return 1'b0;
    end
    return want_zero ? (v == 4'd0) : $onehot(v);
  endfunction

  function automatic logic [1:0] colour(logic [3:0] v);
    logic [1:0] c;
    c = 2'd0;
    for (int j = 0; j < 4; j++) begin
      if (v[j]) c = 2'(j);
    end
    return c;
  endfunction

  task automatic model_step();
    if (rst_input) begin
      m_phase = 0; m_seq = 32'd0; m_pc = 0; m_idle = 0; m_to = 1'b0;
      m_hist.delete();
    end else begin
      case (m_phase)
        0: if (en_input) begin
          m_phase = 1; m_seq = 32'd0; m_pc = 0; m_idle = 0;
          m_target = int'(round_ctr_in) + 1;
          m_hist.delete();
        end
        1: begin
          m_hist.push_back(buttons);
          m_idle++;
          if (last_d_stable(1'b0)) begin
            m_seq[2*m_pc +: 2] = colour(m_hist[$]);
            m_pc++;
            m_phase = 2; m_idle = 0;
            m_hist.delete();
          end else if (TO_EN && m_idle == TO) begin
            m_phase = 3; m_to = 1'b1;
          end
        end
        2: begin
          m_hist.push_back(buttons);
          if (last_d_stable(1'b1)) begin
            m_phase = (m_pc == m_target) ? 3 : 1;
            m_hist.delete();
          end
        end
        default: begin
          m_phase = 0; m_to = 1'b0;
        end
      endcase
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    if (complete_input) pulses++;
    if (timed_out) to_pulses++;
    check("seq_in_check", seq_in_check, m_seq);
    check("press_count", 32'(press_count), 32'(m_pc));
    check("complete_input", 32'(complete_input), 32'(m_phase == 3));
    check("timed_out", 32'(timed_out), 32'(m_phase == 3 && m_to));
  endtask

  task automatic hold(int n, logic [3:0] b);
    buttons = b;
    repeat (n) tick();
  endtask

  task automatic start(logic [3:0] r);
    round_ctr_in = r;
    en_input = 1'b1;
    tick();
    en_input = 1'b0;
  endtask

  task automatic press(logic [3:0] b);
    hold(D, b);
    hold(D, 4'd0);
  endtask

  task automatic do_reset();
    rst_input = 1'b1;
    tick();
    rst_input = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; pulses = 0; to_pulses = 0;
    m_phase = 0; m_seq = 32'd0; m_pc = 0; m_target = 0; m_idle = 0; m_to = 1'b0;
    rst_input = 1'b1; en_input = 1'b0; buttons = 4'd0; round_ctr_in = 4'd0;
    tick();
    tick();
    check("rst_seq", seq_in_check, 32'd0);
    check("rst_count", 32'(press_count), 32'd0);
    check("rst_complete", 32'(complete_input), 32'd0);
    rst_input = 1'b0;

    // single press, round 0
    pulses = 0;
    start(4'd0);
    press(4'b0100);
    hold(3, 4'd0);
    check("r0_pulses", 32'(pulses), 32'd1);
    check("r0_seq", seq_in_check, 32'h0000_0002);
    check("r0_count", 32'(press_count), 32'd1);

    // four colours, with en and round changes mid-sequence ignored
    pulses = 0;
    start(4'd3);
    round_ctr_in = 4'd0;
    en_input = 1'b1;
    hold(D, 4'b0001);
    en_input = 1'b0;
    hold(D, 4'd0);
    press(4'b0010);
    press(4'b0100);
    press(4'b1000);
    hold(3, 4'd0);
    check("r3_pulses", 32'(pulses), 32'd1);
    check("r3_seq", seq_in_check, 32'h0000_00E4);
    check("r3_count", 32'(press_count), 32'd4);

    // multi-bit and short presses never count
    pulses = 0;
    start(4'd0);
    hold(20, 4'b0011);
    hold(3, 4'b0001);
    hold(10, 4'd0);
    check("glitch_pulses", 32'(pulses), 32'd0);
    check("glitch_count", 32'(press_count), 32'd0);
    check("glitch_seq", seq_in_check, 32'd0);
    do_reset();

    // reset mid-sequence, then a clean round
    start(4'd3);
    press(4'b0001);
    press(4'b0010);
    hold(2, 4'b0100);
    buttons = 4'd0;
    do_reset();
    check("midrst_seq", seq_in_check, 32'd0);
    check("midrst_count", 32'(press_count), 32'd0);
    pulses = 0;
    start(4'd0);
    press(4'b0010);
    hold(3, 4'd0);
    check("after_rst_seq", seq_in_check, 32'h0000_0001);
    check("after_rst_count", 32'(press_count), 32'd1);
    check("after_rst_pulses", 32'(pulses), 32'd1);

    // button held across en only counts cycles spent waiting for a press
    pulses = 0;
    buttons = 4'b0001;
    start(4'd0);
    hold(3, 4'b0001);
    hold(6, 4'd0);
    check("held_count", 32'(press_count), 32'd0);
    press(4'b1000);
    hold(3, 4'd0);
    check("held_seq", seq_in_check, 32'h0000_0003);
    check("held_count2", 32'(press_count), 32'd1);
    check("held_pulses", 32'(pulses), 32'd1);

    // round 15 fills the whole word
    pulses = 0;
    start(4'd15);
    for (int i = 0; i < 16; i++) press(4'b1000);
    hold(3, 4'd0);
    check("full_seq", seq_in_check, 32'hFFFF_FFFF);
    check("full_count", 32'(press_count), 32'd16);
    check("full_pulses", 32'(pulses), 32'd1);

    // one press then silence
    pulses = 0; to_pulses = 0;
    start(4'd3);
    press(4'b0001);
`ifdef INPUT_TIMEOUT_EN
    hold(60, 4'd0);
    check("to_pulses", 32'(pulses), 32'd1);
    check("to_timed", 32'(to_pulses), 32'd1);
    check("to_count", 32'(press_count), 32'd1);
`else
    hold(200, 4'd0);
    check("noto_pulses", 32'(pulses), 32'd0);
    check("noto_timed", 32'(to_pulses), 32'd0);
    check("noto_count", 32'(press_count), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
